// File: rtl/combination_entry_sequencer_pkg.sv
// Shared encodings and helpers for the combination entry sequencer and lock tests.
package combination_entry_sequencer_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned STEP_W = 2;

    localparam logic [STEP_W-1:0] LAST_STEP = 2'd2;

    typedef enum logic [1:0] {
        LOCK_S0 = 2'b00,
        LOCK_S1 = 2'b01,
        LOCK_S2 = 2'b10,
        LOCK_S3 = 2'b11
    } lock_state_e;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'b00,
        SEQ_DRIVE = 2'b01,
        SEQ_GAP   = 2'b10,
        SEQ_CHECK = 2'b11
    } seq_state_e;

    typedef struct packed {
        logic key2;
        logic key1;
    } keys_t;

    // Bit n set means step n uses Key2; all other steps use Key1.
    localparam logic [3:0] STEP_KEY2_MAP = 4'b0010;

    function automatic keys_t step_keys(input logic [STEP_W-1:0] step);
        keys_t k;
        k.key2 = STEP_KEY2_MAP[step];
        k.key1 = ~STEP_KEY2_MAP[step];
        return k;
    endfunction

    function automatic lock_state_e lock_after_step(input logic [STEP_W-1:0] step);
        return lock_state_e'(step + STEP_W'(1));
    endfunction

endpackage

// File: rtl/combination_entry_sequencer_phase_timer.sv
// Loadable down-counter timing the HOLD, GAP and TIMEOUT phases.
module combination_entry_sequencer_phase_timer
    import combination_entry_sequencer_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_c_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero_c_o = (count_q == '0);

endmodule

// File: rtl/combination_entry_sequencer.sv
// Drives the three (key, password) steps of the combination lock and reports Done/Fail.
module combination_entry_sequencer
    import combination_entry_sequencer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic [CODE_W-1:0] Code0,
    input  logic [CODE_W-1:0] Code1,
    input  logic [CODE_W-1:0] Code2,
    input  logic [1:0]        LockState,
    output logic              Key1,
    output logic              Key2,
    output logic [CODE_W-1:0] Password,
    output logic              Busy,
    output logic              Done,
    output logic              Fail
);

    // Timer is loaded with N-1 so that a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);

    seq_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CODE_W-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
    logic              key1_q, key1_d, key2_q, key2_d;
    logic [CODE_W-1:0] pwd_q, pwd_d;
    logic              busy_q;
    logic              done_q, done_d, fail_q, fail_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_en;
    logic              tmr_zero;

    function automatic logic [CODE_W-1:0] code_for_step(input logic [STEP_W-1:0] step,
                                                        input logic [CODE_W-1:0] a,
                                                        input logic [CODE_W-1:0] b,
                                                        input logic [CODE_W-1:0] c);
        case (step)
            2'd0:    return a;
            2'd1:    return b;
            default: return c;
        endcase
    endfunction

    combination_entry_sequencer_phase_timer u_timer (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_c_o   (tmr_zero)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= SEQ_IDLE;
            step_q  <= '0;
            c0_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            key1_q  <= 1'b0;
            key2_q  <= 1'b0;
            pwd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            key1_q  <= key1_d;
            key2_q  <= key2_d;
            pwd_q   <= pwd_d;
            busy_q  <= (state_d != SEQ_IDLE);
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    // Outputs are computed for the next state so they are visible the cycle after the edge.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        c0_d     = c0_q;
        c1_d     = c1_q;
        c2_d     = c2_q;
        key1_d   = key1_q;
        key2_d   = key2_q;
        pwd_d    = pwd_q;
        done_d   = done_q;
        fail_d   = fail_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (Start) begin
                    c0_d             = Code0;
                    c1_d             = Code1;
                    c2_d             = Code2;
                    step_d           = '0;
                    done_d           = 1'b0;
                    fail_d           = 1'b0;
                    {key2_d, key1_d} = step_keys(STEP_W'(0));
                    pwd_d            = Code0;
                    tmr_load         = 1'b1;
                    tmr_val          = HOLD_LOAD;
                    state_d          = SEQ_DRIVE;
                end
            end
            SEQ_DRIVE: begin
                if (tmr_zero) begin
                    key1_d   = 1'b0;
                    key2_d   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                    state_d  = SEQ_GAP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            SEQ_GAP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TIMEOUT_LOAD;
                    state_d  = SEQ_CHECK;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            SEQ_CHECK: begin
                // A match in the final timeout cycle still counts as success.
                if (LockState == lock_after_step(step_q)) begin
                    if (step_q == LAST_STEP) begin
                        done_d  = 1'b1;
                        pwd_d   = '0;
                        state_d = SEQ_IDLE;
                    end else begin
                        step_d           = step_q + STEP_W'(1);
                        {key2_d, key1_d} = step_keys(step_d);
                        pwd_d            = code_for_step(step_d, c0_q, c1_q, c2_q);
                        tmr_load         = 1'b1;
                        tmr_val          = HOLD_LOAD;
                        state_d          = SEQ_DRIVE;
                    end
                end else if (tmr_zero) begin
                    fail_d  = 1'b1;
                    pwd_d   = '0;
                    state_d = SEQ_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase

        if (Abort && (state_q != SEQ_IDLE)) begin
            state_d  = SEQ_IDLE;
            step_d   = '0;
            key1_d   = 1'b0;
            key2_d   = 1'b0;
            pwd_d    = '0;
            done_d   = 1'b0;
            fail_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = '0;
            tmr_en   = 1'b0;
        end
    end

    assign Key1     = key1_q;
    assign Key2     = key2_q;
    assign Password = pwd_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Fail     = fail_q;

endmodule

// File: tb/tb_combination_entry_sequencer.sv
// Scoreboard bench: default-timing and 1/1/1-timing sequencers, each driving a small lock model.
module tb_combination_entry_sequencer;

    typedef struct packed {
        logic done;
        logic fail;
        int   cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, lock_rst;
    logic       start, abort, start_f, abort_f;
    logic [3:0] code0, code1, code2;
    logic [1:0] ls, ls_f;
    logic       key1, key2, busy, done, fail;
    logic [3:0] pwd;
    logic       key1_f, key2_f, busy_f, done_f, fail_f;
    logic [3:0] pwd_f;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   start_cyc   = 0;
    int   start_cyc_f = 0;
    exp_t exp_q[$];
    exp_t exp_q_f[$];
    logic busy_prev   = 1'b0;
    logic busy_prev_f = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    combination_entry_sequencer dut (
        .Clk(clk), .Reset(rst), .Start(start), .Abort(abort),
        .Code0(code0), .Code1(code1), .Code2(code2), .LockState(ls),
        .Key1(key1), .Key2(key2), .Password(pwd),
        .Busy(busy), .Done(done), .Fail(fail)
    );

    combination_entry_sequencer #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .TIMEOUT(1)) dut_f (
        .Clk(clk), .Reset(rst), .Start(start_f), .Abort(abort_f),
        .Code0(code0), .Code1(code1), .Code2(code2), .LockState(ls_f),
        .Key1(key1_f), .Key2(key2_f), .Password(pwd_f),
        .Busy(busy_f), .Done(done_f), .Fail(fail_f)
    );

    // Lock with secret 13 (Key1), 7 (Key2), 9 (Key1); wrong entries leave the state unchanged.
    function automatic logic [1:0] lock_next(input logic [1:0] s, input logic k1, input logic k2,
                                             input logic [3:0] p);
        case (s)
            2'b00:   return (k1 && !k2 && p == 4'd13) ? 2'b01 : s;
            2'b01:   return (k2 && !k1 && p == 4'd7)  ? 2'b10 : s;
            2'b10:   return (k1 && !k2 && p == 4'd9)  ? 2'b11 : s;
            default: return s;
        endcase
    endfunction

    always @(posedge clk or posedge lock_rst) begin
        if (lock_rst) ls <= 2'b00;
        else          ls <= lock_next(ls, key1, key2, pwd);
    end

    always @(posedge clk or posedge lock_rst) begin
        if (lock_rst) ls_f <= 2'b00;
        else          ls_f <= lock_next(ls_f, key1_f, key2_f, pwd_f);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cycle numbering: the edge that samples Start is cycle 1.
    task automatic sb_pop(input bit fast);
        exp_t e;
        int   c;
        if ((fast ? exp_q_f.size() : exp_q.size()) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got completion at cycle %0d, expected none", cyc);
            return;
        end
        e = fast ? exp_q_f.pop_front() : exp_q.pop_front();
        c = cyc - (fast ? start_cyc_f : start_cyc) + 1;
        chk(fast ? "sb_f_done"  : "sb_done",  int'(fast ? done_f : done), int'(e.done));
        chk(fast ? "sb_f_fail"  : "sb_fail",  int'(fast ? fail_f : fail), int'(e.fail));
        chk(fast ? "sb_f_cycle" : "sb_cycle", c, e.cyc);
        chk(fast ? "sb_f_keys"  : "sb_keys",  int'({fast ? key1_f : key1, fast ? key2_f : key2}), 0);
        chk(fast ? "sb_f_pwd"   : "sb_pwd",   int'(fast ? pwd_f : pwd), 0);
    endtask

    always @(negedge clk) begin
        if (busy_prev && !busy) sb_pop(1'b0);
        busy_prev <= busy;
    end

    always @(negedge clk) begin
        if (busy_prev_f && !busy_f) sb_pop(1'b1);
        busy_prev_f <= busy_f;
    end

    task automatic start_seq(input bit fast, input logic [3:0] c0, input logic [3:0] c1,
                             input logic [3:0] c2, input logic with_abort);
        @(negedge clk);
        code0 = c0;
        code1 = c1;
        code2 = c2;
        abort = with_abort;
        if (fast) begin
            start_f     = 1'b1;
            start_cyc_f = cyc + 1;
        end else begin
            start     = 1'b1;
            start_cyc = cyc + 1;
        end
        @(negedge clk);
        start   = 1'b0;
        start_f = 1'b0;
        abort   = 1'b0;
    endtask

    // Sample k is taken after edge Start+k: hold, then gap, then one matching CHECK cycle per step.
    task automatic check_trace(input bit fast, input int hold, input int gap, input logic [3:0] c0,
                               input logic [3:0] c1, input logic [3:0] c2, input int nk,
                               input string tag);
        int per;
        per = hold + gap + 1;
        for (int k = 0; k < nk; k++) begin
            int         s;
            int         p;
            logic [3:0] ec;
            s  = k / per;
            p  = k % per;
            ec = (s == 0) ? c0 : (s == 1) ? c1 : c2;
            chk({tag, "_key1"}, int'(fast ? key1_f : key1), int'((p < hold) && (s != 1)));
            chk({tag, "_key2"}, int'(fast ? key2_f : key2), int'((p < hold) && (s == 1)));
            chk({tag, "_pwd"},  int'(fast ? pwd_f : pwd),   int'(ec));
            chk({tag, "_busy"}, int'(fast ? busy_f : busy), 1);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input bit fast, input int budget, input string tag);
        int n;
        n = 0;
        while ((fast ? busy_f : busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, int'(fast ? busy_f : busy), 0);
    endtask

    task automatic pulse_lock_rst();
        lock_rst = 1'b1;
        @(negedge clk);
        lock_rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        lock_rst = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        start_f  = 1'b0;
        abort_f  = 1'b0;
        code0    = 4'd0;
        code1    = 4'd0;
        code2    = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_key1", int'(key1), 0);
        chk("rst_key2", int'(key2), 0);
        chk("rst_pwd",  int'(pwd), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_f_busy", int'(busy_f), 0);
        rst      = 1'b0;
        lock_rst = 1'b0;
        @(negedge clk);

        // Clean run with the correct codes.
        exp_q.push_back('{done: 1'b1, fail: 1'b0, cyc: 22});
        start_seq(1'b0, 4'd13, 4'd7, 4'd9, 1'b0);
        check_trace(1'b0, 4, 2, 4'd13, 4'd7, 4'd9, 21, "t1");
        wait_idle(1'b0, 5, "t1");
        chk("t1_lock", int'(ls), 3);
        // Abort in IDLE must leave Done held.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_done", int'(done), 1);
        chk("idle_abort_busy", int'(busy), 0);
        pulse_lock_rst();

        // Wrong step-1 code: Fail 16 cycles after step-1 CHECK entry (edge Start+13).
        exp_q.push_back('{done: 1'b0, fail: 1'b1, cyc: 30});
        start_seq(1'b0, 4'd13, 4'd5, 4'd9, 1'b0);
        chk("t2_done_clr", int'(done), 0);
        check_trace(1'b0, 4, 2, 4'd13, 4'd5, 4'd9, 14, "t2");
        wait_idle(1'b0, 40, "t2");
        chk("t2_lock", int'(ls), 1);
        pulse_lock_rst();

        // Abort during step-1 DRIVE.
        exp_q.push_back('{done: 1'b0, fail: 1'b0, cyc: 9});
        start_seq(1'b0, 4'd13, 4'd7, 4'd9, 1'b0);
        chk("t3_fail_clr", int'(fail), 0);
        check_trace(1'b0, 4, 2, 4'd13, 4'd7, 4'd9, 7, "t3");
        chk("t3_key2_pre", int'(key2), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t3_key2",  int'(key2), 0);
        chk("t3_pwd",   int'(pwd), 0);
        chk("t3_busy",  int'(busy), 0);
        chk("t3_done",  int'(done), 0);
        chk("t3_fail",  int'(fail), 0);
        pulse_lock_rst();

        // Start+Abort together starts; later Start and a Code0 change are ignored.
        exp_q.push_back('{done: 1'b1, fail: 1'b0, cyc: 22});
        start_seq(1'b0, 4'd13, 4'd7, 4'd9, 1'b1);
        chk("t5_busy", int'(busy), 1);
        chk("t5_key1_k0", int'(key1), 1);
        chk("t5_pwd_k0", int'(pwd), 13);
        code0 = 4'd3;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_key1_k3", int'(key1), 1);
        chk("t5_pwd_k3", int'(pwd), 13);
        wait_idle(1'b0, 30, "t5");
        chk("t5_lock", int'(ls), 3);
        code0 = 4'd13;
        pulse_lock_rst();

        // Asynchronous reset between edges Start+4 and Start+5 (GAP); first negedge after it is cycle 6.
        exp_q.push_back('{done: 1'b0, fail: 1'b0, cyc: 6});
        start_seq(1'b0, 4'd13, 4'd7, 4'd9, 1'b0);
        repeat (4) @(negedge clk);
        chk("t4_pwd_pre", int'(pwd), 13);
        #2 rst = 1'b1;
        #1;
        chk("t4_key1", int'(key1), 0);
        chk("t4_key2", int'(key2), 0);
        chk("t4_pwd",  int'(pwd), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_done", int'(done), 0);
        chk("t4_fail", int'(fail), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_no_resume_busy", int'(busy), 0);
        chk("t4_no_resume_key1", int'(key1), 0);
        chk("t4_no_resume_pwd",  int'(pwd), 0);
        pulse_lock_rst();

        // Minimum timing: one-cycle key pulses, Done at cycle 10.
        exp_q_f.push_back('{done: 1'b1, fail: 1'b0, cyc: 10});
        start_seq(1'b1, 4'd13, 4'd7, 4'd9, 1'b0);
        check_trace(1'b1, 1, 1, 4'd13, 4'd7, 4'd9, 9, "t6");
        wait_idle(1'b1, 5, "t6");
        chk("t6_lock", int'(ls_f), 3);

        repeat (3) @(negedge clk);
        chk("sb_left",   exp_q.size(), 0);
        chk("sb_left_f", exp_q_f.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
